debug_retire_trace: RTL and testbench
=====================================

Name: debug_retire_trace

Overview:
- Debug-only trace buffer fed directly by the MEM/WB debug pipeline register outputs (o_dbgTick ... o_dbgMemAccess).
- Captures one record per retired instruction into a FIFO and hands records out over a valid/ready stream to the simulation trace dumper or debug port.
- Drops bubble/flush slots (instruction word 0).
- Reports overflow instead of stalling the core; it never back-pressures the pipeline.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the dropped-record counter.

Ports:
- i_clock  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  capture enable; 0 = no new records, drain continues.
- i_clear  in  1  synchronous clear of FIFO, overflow flag, drop counter.
- i_dbgTick  in  int (32)  tick number of retiring instruction.
- i_dbgPc  in  InstAddr  PC of retiring instruction.
- i_dbgInst  in  Inst  instruction word; 0 = bubble.
- i_dbgMemWrAddr  in  DataAddr  store address.
- i_dbgMemWrEnable  in  1  store performed.
- i_dbgMemWrData  in  Data  store data.
- i_dbgMemAccess  in  DataAccess  store access size.
- o_valid  out  1  head record available.
- i_ready  in  1  consumer accepts head record.
- o_tick, o_pc, o_inst, o_memWrAddr, o_memWrEnable, o_memWrData, o_memAccess  out  same types as inputs  head record fields.
- o_count  out  $clog2(DEPTH+1)  entries held.
- o_overflow  out  1  sticky: at least one record dropped.
- o_dropped  out  CNT_W  dropped-record count, saturating.

Behaviour:
- Reset (i_reset=0, asynchronous): count=0, read/write pointers=0, o_valid=0, o_overflow=0, o_dropped=0; all record outputs 0. Storage array contents are don't-care.
- push_req = i_enable && (i_dbgInst != 0). Sampled on the rising edge.
- pop = o_valid && i_ready.
- push accepted when count < DEPTH, or count == DEPTH and pop in the same cycle (push-while-pop when full is allowed).
- Push request not accepted: record discarded, o_overflow <= 1, o_dropped <= o_dropped+1. The counter saturates at all-ones and never wraps.
- FIFO is show-ahead: o_valid = (count != 0); record outputs show the head entry combinationally from storage indexed by the read pointer.
- When o_valid=0, record outputs must be 0 (masked), not stale data.
- Latency: a record captured at edge N is visible on the outputs after edge N, provided the FIFO was empty.
- Push and pop on an empty FIFO in the same cycle: pop is ignored because o_valid=0. Count becomes 1.
- Push and pop in the same cycle, count in 1..DEPTH: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full/empty are derived from count only.
- o_valid and the head record must stay stable while o_valid=1 and i_ready=0.
- i_clear=1 has priority over push and pop in that cycle:
  - count, pointers, o_overflow and o_dropped go to 0;
  - the input record presented that cycle is not stored and not counted as dropped;
  - no pop is counted.
- i_enable=0: no pushes and no drop counting; popping is unaffected.
- Reset asserted mid-stream: FIFO empties immediately (asynchronously). After deassertion, the first accepted push is stored at index 0.
- Record fields are stored unmodified. Tick is stored as given, including the MEM/WB flush-tick behaviour; no filtering on store enable.

Test Plan:
- Reset, then push 3 records with PC 0x100/0x104/0x108, inst 0x00000013, i_ready=0 -> o_count=3, head pc=0x100. Raise i_ready -> records emerge in order over 3 cycles, then o_valid=0 and outputs 0.
- Push sequence with interleaved i_dbgInst=0 slots (flush bubbles) -> only the non-zero instructions are stored; o_count equals the number of non-zero slots.
- DEPTH=16, i_ready=0, push 20 records -> o_count=16, o_overflow=1, o_dropped=4, head is the first record. Then push and pop together at full -> o_count stays 16, o_dropped stays 4.
- Store record (i_dbgMemWrEnable=1, addr 0x2000, data 0xDEADBEEF, word access) -> the same values appear on the o_mem* outputs. Push/pop 40 records continuously -> pointer wrap-around loses or reorders no record.
- Preload 5 records with o_dropped=2, then assert i_clear together with a valid push -> next cycle o_count=0, o_valid=0, o_overflow=0, o_dropped=0; the concurrent record is absent.
- Assert i_reset low mid-drain with o_count=7 -> outputs zero asynchronously, before the next clock edge. After release, the first push is output correctly and o_count=1.

Source files
------------

// File: rtl/debug_retire_trace.sv
// Retire trace buffer: captures one record per retired (non-bubble) instruction
// into a show-ahead FIFO; never stalls the core, counts dropped records instead.
module debug_retire_trace #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_clear,
    input  logic [31:0]                  i_dbgTick,
    input  logic [31:0]                  i_dbgPc,
    input  logic [31:0]                  i_dbgInst,
    input  logic [31:0]                  i_dbgMemWrAddr,
    input  logic                         i_dbgMemWrEnable,
    input  logic [31:0]                  i_dbgMemWrData,
    input  logic [1:0]                   i_dbgMemAccess,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [31:0]                  o_tick,
    output logic [31:0]                  o_pc,
    output logic [31:0]                  o_inst,
    output logic [31:0]                  o_memWrAddr,
    output logic                         o_memWrEnable,
    output logic [31:0]                  o_memWrData,
    output logic [1:0]                   o_memAccess,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow,
    output logic [CNT_W-1:0]             o_dropped
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = $clog2(DEPTH+1);
    localparam int REC_W   = 32 + 32 + 32 + 32 + 1 + 32 + 2;

    // Stream handshake: o_valid means the head record is on the outputs; a record
    // transfers on a rising edge where o_valid && i_ready. While o_valid=1 and
    // i_ready=0 the head record and o_valid hold steady.

    logic [REC_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [COUNT_W-1:0] count;
    logic               overflow;
    logic [CNT_W-1:0]   dropped;

    logic               pushReq;
    logic               pop;
    logic               full;
    logic               pushOk;
    logic               drop;
    logic [REC_W-1:0]   inRec;
    logic [REC_W-1:0]   headRec;

    assign inRec   = {i_dbgTick, i_dbgPc, i_dbgInst, i_dbgMemWrAddr,
                      i_dbgMemWrEnable, i_dbgMemWrData, i_dbgMemAccess};
    assign o_valid = (count != '0);
    assign pushReq = i_enable && (i_dbgInst != 32'd0);
    assign pop     = o_valid && i_ready;
    assign full    = (count == COUNT_W'(DEPTH));
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign pushOk  = pushReq && (!full || pop);
    assign drop    = pushReq && !pushOk;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dropped  <= '0;
        end else if (i_clear) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dropped  <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (pop)    rdPtr <= rdPtr + 1'b1;
            case ({pushOk, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (dropped != {CNT_W{1'b1}}) dropped <= dropped + 1'b1;
            end
        end
    end

    // Storage needs no reset; entries are only visible while counted.
    always_ff @(posedge i_clock) begin
        if (i_reset && !i_clear && pushOk) mem[wrPtr] <= inRec;
    end

    assign headRec = o_valid ? mem[rdPtr] : '0;
    assign {o_tick, o_pc, o_inst, o_memWrAddr,
            o_memWrEnable, o_memWrData, o_memAccess} = headRec;

    assign o_count    = count;
    assign o_overflow = overflow;
    assign o_dropped  = dropped;

endmodule

// File: tb/tb_debug_retire_trace.sv
// Bench for debug_retire_trace: scoreboard queue of expected records, one task per scenario.
module tb_debug_retire_trace;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 16;
    localparam int COUNT_W = $clog2(DEPTH+1);
    localparam int REC_W   = 163;

    logic               i_clock;
    logic               i_reset;
    logic               i_enable;
    logic               i_clear;
    logic [31:0]        i_dbgTick;
    logic [31:0]        i_dbgPc;
    logic [31:0]        i_dbgInst;
    logic [31:0]        i_dbgMemWrAddr;
    logic               i_dbgMemWrEnable;
    logic [31:0]        i_dbgMemWrData;
    logic [1:0]         i_dbgMemAccess;
    logic               o_valid;
    logic               i_ready;
    logic [31:0]        o_tick;
    logic [31:0]        o_pc;
    logic [31:0]        o_inst;
    logic [31:0]        o_memWrAddr;
    logic               o_memWrEnable;
    logic [31:0]        o_memWrData;
    logic [1:0]         o_memAccess;
    logic [COUNT_W-1:0] o_count;
    logic               o_overflow;
    logic [CNT_W-1:0]   o_dropped;

    logic [REC_W-1:0] exp_q[$];
    logic             expOverflow;
    logic [CNT_W-1:0] expDropped;
    int               nChecks;
    int               nErrors;

    debug_retire_trace #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_clear),
        .i_dbgTick(i_dbgTick), .i_dbgPc(i_dbgPc), .i_dbgInst(i_dbgInst),
        .i_dbgMemWrAddr(i_dbgMemWrAddr), .i_dbgMemWrEnable(i_dbgMemWrEnable),
        .i_dbgMemWrData(i_dbgMemWrData), .i_dbgMemAccess(i_dbgMemAccess),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_tick(o_tick), .o_pc(o_pc), .o_inst(o_inst), .o_memWrAddr(o_memWrAddr),
        .o_memWrEnable(o_memWrEnable), .o_memWrData(o_memWrData), .o_memAccess(o_memAccess),
        .o_count(o_count), .o_overflow(o_overflow), .o_dropped(o_dropped)
    );

    // Clock and reset
    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    function automatic logic [REC_W-1:0] headRec();
        return {o_tick, o_pc, o_inst, o_memWrAddr, o_memWrEnable, o_memWrData, o_memAccess};
    endfunction

    function automatic logic [REC_W-1:0] curRec();
        return {i_dbgTick, i_dbgPc, i_dbgInst, i_dbgMemWrAddr,
                i_dbgMemWrEnable, i_dbgMemWrData, i_dbgMemAccess};
    endfunction

    function automatic logic [REC_W-1:0] rndRec(logic [31:0] pc);
        logic [31:0] inst;
        inst = $urandom() | 32'h1;
        return {$urandom(), pc, inst, $urandom(), 1'($urandom_range(0, 1)),
                $urandom(), 2'($urandom_range(0, 3))};
    endfunction

    // Driver
    task automatic setIn(logic [REC_W-1:0] r);
        {i_dbgTick, i_dbgPc, i_dbgInst, i_dbgMemWrAddr,
         i_dbgMemWrEnable, i_dbgMemWrData, i_dbgMemAccess} = r;
    endtask

    // Updates the reference model for the inputs now driven, then advances one cycle.
    task automatic tick();
        bit popM;
        bit pushReq;
        bit acc;
        popM    = (exp_q.size() != 0) && i_ready;
        pushReq = i_enable && (i_dbgInst != 32'd0);
        if (i_clear) begin
            exp_q.delete();
            expOverflow = 1'b0;
            expDropped  = '0;
        end else begin
            acc = pushReq && ((exp_q.size() < DEPTH) || popM);
            if (popM) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(curRec());
            else if (pushReq) begin
                expOverflow = 1'b1;
                if (expDropped != {CNT_W{1'b1}}) expDropped = expDropped + 1'b1;
            end
        end
        @(posedge i_clock);
        @(negedge i_clock);
    endtask

    task automatic test_reset();
        nChecks++;
        if (o_valid !== 1'b0) begin nErrors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        nChecks++;
        if (o_count !== '0) begin nErrors++; $display("FAIL reset_count: got %0d expected 0", o_count); end
        nChecks++;
        if (o_overflow !== 1'b0) begin nErrors++; $display("FAIL reset_overflow: got %b expected 0", o_overflow); end
        nChecks++;
        if (o_dropped !== '0) begin nErrors++; $display("FAIL reset_dropped: got %0d expected 0", o_dropped); end
        nChecks++;
        if (headRec() !== '0) begin nErrors++; $display("FAIL reset_record: got %h expected 0", headRec()); end
    endtask

    task automatic test_basic();
        i_ready = 1'b0; i_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setIn(rndRec(32'h100 + 32'(4 * i)));
            i_dbgInst = 32'h0000_0013;
            tick();
        end
        i_enable = 1'b0;
        nChecks++;
        if (o_count !== 3) begin nErrors++; $display("FAIL basic_count: got %0d expected 3", o_count); end
        nChecks++;
        if (o_pc !== 32'h100) begin nErrors++; $display("FAIL basic_head_pc: got %h expected 100", o_pc); end
        tick();  // stalled cycle: head must hold
        nChecks++;
        if (headRec() !== exp_q[0]) begin nErrors++; $display("FAIL basic_stall_hold: got %h expected %h", headRec(), exp_q[0]); end
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nChecks++;
            if (headRec() !== exp_q[0] || o_valid !== 1'b1) begin
                nErrors++; $display("FAIL basic_drain%0d: got %h expected %h", i, headRec(), exp_q[0]);
            end
            tick();
        end
        nChecks++;
        if (o_valid !== 1'b0 || headRec() !== '0) begin
            nErrors++; $display("FAIL basic_empty_mask: got valid=%b rec=%h expected 0", o_valid, headRec());
        end
    endtask

    task automatic test_bubbles();
        logic [9:0] pattern;
        pattern = 10'b1011001101;  // six real instructions, four bubbles
        i_ready = 1'b0; i_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            setIn(rndRec(32'h200 + 32'(4 * i)));
            if (!pattern[i]) i_dbgInst = 32'd0;
            tick();
        end
        i_enable = 1'b0;
        nChecks++;
        if (o_count !== 6 || exp_q.size() != 6) begin nErrors++; $display("FAIL bubble_count: got %0d expected 6", o_count); end
        i_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2 && exp_q.size() != 0; i++) begin
            nChecks++;
            if (headRec() !== exp_q[0]) begin nErrors++; $display("FAIL bubble_order: got %h expected %h", headRec(), exp_q[0]); end
            tick();
        end
        nChecks++;
        if (o_valid !== 1'b0) begin nErrors++; $display("FAIL bubble_drained: got %b expected 0", o_valid); end
    endtask

    task automatic test_overflow();
        i_ready = 1'b0; i_enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            setIn(rndRec(32'h300 + 32'(4 * i)));
            tick();
        end
        nChecks++;
        if (o_count !== DEPTH) begin nErrors++; $display("FAIL ovf_count: got %0d expected %0d", o_count, DEPTH); end
        nChecks++;
        if (o_overflow !== 1'b1) begin nErrors++; $display("FAIL ovf_flag: got %b expected 1", o_overflow); end
        nChecks++;
        if (o_dropped !== 4 || expDropped != 4) begin nErrors++; $display("FAIL ovf_dropped: got %0d expected 4", o_dropped); end
        nChecks++;
        if (o_pc !== 32'h300 || headRec() !== exp_q[0]) begin nErrors++; $display("FAIL ovf_head: got %h expected %h", headRec(), exp_q[0]); end
        i_ready = 1'b1;
        setIn(rndRec(32'h3F0));
        tick();  // push while pop at full
        i_enable = 1'b0;
        nChecks++;
        if (o_count !== DEPTH) begin nErrors++; $display("FAIL ovf_pushpop_count: got %0d expected %0d", o_count, DEPTH); end
        nChecks++;
        if (o_dropped !== 4) begin nErrors++; $display("FAIL ovf_pushpop_dropped: got %0d expected 4", o_dropped); end
        for (int i = 0; i < DEPTH + 2 && exp_q.size() != 0; i++) begin
            nChecks++;
            if (headRec() !== exp_q[0]) begin nErrors++; $display("FAIL ovf_order: got %h expected %h", headRec(), exp_q[0]); end
            tick();
        end
        nChecks++;
        if (o_valid !== 1'b0) begin nErrors++; $display("FAIL ovf_drained: got %b expected 0", o_valid); end
    endtask

    task automatic test_store_stream();
        logic [REC_W-1:0] r;
        r = rndRec(32'h400);
        setIn(r);
        i_dbgMemWrEnable = 1'b1; i_dbgMemWrAddr = 32'h2000;
        i_dbgMemWrData = 32'hDEAD_BEEF; i_dbgMemAccess = 2'd2;
        i_ready = 1'b0; i_enable = 1'b1;
        tick();
        i_enable = 1'b0;
        nChecks++;
        if (o_memWrEnable !== 1'b1 || o_memWrAddr !== 32'h2000 || o_memWrData !== 32'hDEAD_BEEF || o_memAccess !== 2'd2) begin
            nErrors++; $display("FAIL store_fields: got we=%b addr=%h data=%h acc=%0d expected 1 2000 deadbeef 2",
                                o_memWrEnable, o_memWrAddr, o_memWrData, o_memAccess);
        end
        nChecks++;
        if (headRec() !== exp_q[0]) begin nErrors++; $display("FAIL store_record: got %h expected %h", headRec(), exp_q[0]); end
        i_ready = 1'b1; i_enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            setIn(rndRec(32'h500 + 32'(4 * i)));
            if (exp_q.size() != 0) begin
                nChecks++;
                if (headRec() !== exp_q[0]) begin nErrors++; $display("FAIL stream_order%0d: got %h expected %h", i, headRec(), exp_q[0]); end
            end
            tick();
        end
        i_enable = 1'b0;
        for (int i = 0; i < DEPTH + 2 && exp_q.size() != 0; i++) begin
            nChecks++;
            if (headRec() !== exp_q[0]) begin nErrors++; $display("FAIL stream_tail: got %h expected %h", headRec(), exp_q[0]); end
            tick();
        end
        nChecks++;
        if (o_valid !== 1'b0 || o_dropped !== 4) begin
            nErrors++; $display("FAIL stream_end: got valid=%b dropped=%0d expected 0 4", o_valid, o_dropped);
        end
    endtask

    task automatic test_clear();
        i_clear = 1'b1; i_enable = 1'b0;
        tick();
        i_clear = 1'b0; i_ready = 1'b0; i_enable = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            setIn(rndRec(32'h600 + 32'(4 * i)));
            tick();
        end
        i_enable = 1'b0; i_ready = 1'b1;
        for (int i = 0; i < DEPTH - 5; i++) begin
            nChecks++;
            if (headRec() !== exp_q[0]) begin nErrors++; $display("FAIL clear_predrain: got %h expected %h", headRec(), exp_q[0]); end
            tick();
        end
        i_ready = 1'b0;
        nChecks++;
        if (o_count !== 5 || o_dropped !== 2) begin
            nErrors++; $display("FAIL clear_preload: got count=%0d dropped=%0d expected 5 2", o_count, o_dropped);
        end
        i_clear = 1'b1; i_enable = 1'b1;
        setIn(rndRec(32'h700));
        tick();
        i_clear = 1'b0; i_enable = 1'b0;
        nChecks++;
        if (o_count !== 0 || o_valid !== 1'b0) begin
            nErrors++; $display("FAIL clear_empty: got count=%0d valid=%b expected 0 0", o_count, o_valid);
        end
        nChecks++;
        if (o_overflow !== 1'b0 || o_dropped !== 0) begin
            nErrors++; $display("FAIL clear_flags: got ovf=%b dropped=%0d expected 0 0", o_overflow, o_dropped);
        end
        tick();
        nChecks++;
        if (o_count !== 0 || headRec() !== '0) begin
            nErrors++; $display("FAIL clear_record_absent: got count=%0d rec=%h expected 0", o_count, headRec());
        end
    endtask

    task automatic test_async_reset();
        logic [REC_W-1:0] r;
        i_ready = 1'b0; i_enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            setIn(rndRec(32'h800 + 32'(4 * i)));
            tick();
        end
        i_enable = 1'b0; i_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (headRec() !== exp_q[0]) begin nErrors++; $display("FAIL areset_predrain: got %h expected %h", headRec(), exp_q[0]); end
            tick();
        end
        nChecks++;
        if (o_count !== 7) begin nErrors++; $display("FAIL areset_precount: got %0d expected 7", o_count); end
        i_reset = 1'b0;
        exp_q.delete(); expOverflow = 1'b0; expDropped = '0;
        #1;
        nChecks++;
        if (o_valid !== 1'b0 || o_count !== 0 || headRec() !== '0) begin
            nErrors++; $display("FAIL areset_immediate: got valid=%b count=%0d rec=%h expected 0", o_valid, o_count, headRec());
        end
        @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1; i_ready = 1'b0; i_enable = 1'b1;
        r = rndRec(32'h900);
        setIn(r);
        tick();
        i_enable = 1'b0;
        nChecks++;
        if (o_count !== 1) begin nErrors++; $display("FAIL areset_count: got %0d expected 1", o_count); end
        nChecks++;
        if (headRec() !== r) begin nErrors++; $display("FAIL areset_first: got %h expected %h", headRec(), r); end
        i_ready = 1'b1;
        tick();
        nChecks++;
        if (o_valid !== 1'b0 || exp_q.size() != 0) begin nErrors++; $display("FAIL areset_drain: got %b expected 0", o_valid); end
    endtask

    initial begin
        nChecks = 0; nErrors = 0;
        expOverflow = 1'b0; expDropped = '0;
        i_reset = 1'b0; i_enable = 1'b0; i_clear = 1'b0; i_ready = 1'b0;
        setIn('0);
        repeat (2) @(negedge i_clock);
        test_reset();
        i_reset = 1'b1;
        @(negedge i_clock);
        test_reset();
        test_basic();
        test_bubbles();
        test_overflow();
        test_store_stream();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
